// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: Clause 22/45 start and opcode fields, the master's
// state type and the read-opcode decode used by the controller.
package mdio_pkg;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WRITE    = 2'b01;
  localparam logic [1:0] OP_C22_READ     = 2'b10;
  localparam logic [1:0] OP_C45_ADDR     = 2'b00;
  localparam logic [1:0] OP_C45_WRITE    = 2'b01;
  localparam logic [1:0] OP_C45_READ     = 2'b11;
  localparam logic [1:0] OP_C45_READ_INC = 2'b10;

  // Turnaround the master drives on write and address frames.
  localparam logic [1:0] TA_WRITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_FRAME,
    S_GAP,
    S_ERR
  } state_t;

  function automatic logic is_read(input logic c45, input logic [1:0] op);
    if (c45) return (op == OP_C45_READ) || (op == OP_C45_READ_INC);
    else     return (op == OP_C22_READ);
  endfunction

  function automatic logic is_legal(input logic c45, input logic [1:0] op);
    return c45 || (op == OP_C22_WRITE) || (op == OP_C22_READ);
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: divides clk by 2*CLK_DIV while run is high and flags the
// clock edges at which MDC is about to rise or fall.
module mdio_clkgen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;
  logic          half_end;

  // Strobes are valid in the cycle before the MDC transition, so logic
  // clocked on them updates at the same edge MDC moves.
  assign half_end = run && (cnt == CNT_LAST);
  assign rise_stb = half_end && !mdc;
  assign fall_stb = half_end && mdc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end

endmodule

// File: rtl/mdio_ctrl.sv
// MDIO management master: accepts one request, runs a Clause 22/45 frame with
// optional preamble, then reports read data or an error on a one-cycle pulse.
module mdio_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_c45,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  // bit_cnt counts down within a state; these are its values on the TA bits.
  localparam logic [5:0] TA1_CNT = 6'd17;
  localparam logic [5:0] TA2_CNT = 6'd16;

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [31:0] shreg;
  logic [31:0] frame_req;
  logic        rd_q;
  logic        ta_err;
  logic        run;
  logic        fall_stb;
  logic        rise_stb;

  assign run       = (state == S_PRE) || (state == S_FRAME) || (state == S_GAP);
  assign frame_req = {(req_c45 ? ST_C45 : ST_C22), req_op, req_phyad, req_regad,
                      TA_WRITE, req_data};
  assign rsp_valid = (state == S_ERR) || ((state == S_GAP) && fall_stb);

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // Read data is sampled into the low end of the frame register; each fall
  // shifts it up, so after the last DATA bit shreg[15:0] holds the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rd_q      <= 1'b0;
      ta_err    <= 1'b0;
      req_ready <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            ta_err    <= 1'b0;
            if (!is_legal(req_c45, req_op)) begin
              state    <= S_ERR;
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end else begin
              rd_q    <= is_read(req_c45, req_op);
              shreg   <= frame_req;
              mdio_oe <= 1'b1;
              if (PRE_LEN == 0) begin
                state   <= S_FRAME;
                bit_cnt <= 6'd31;
                mdio_o  <= frame_req[31];
              end else begin
                state   <= S_PRE;
                bit_cnt <= 6'(PRE_LEN - 1);
                mdio_o  <= 1'b1;
              end
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_PRE: begin
          if (fall_stb) begin
            if (bit_cnt == 6'd0) begin
              state   <= S_FRAME;
              bit_cnt <= 6'd31;
              mdio_o  <= shreg[31];
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
            end
          end
        end

        S_FRAME: begin
          if (rise_stb && rd_q) begin
            if (bit_cnt == TA2_CNT) ta_err <= mdio_i;
            else if (bit_cnt < TA2_CNT) shreg[0] <= mdio_i;
          end
          if (fall_stb) begin
            if (bit_cnt == 6'd0) begin
              state    <= S_GAP;
              mdio_o   <= 1'b1;
              mdio_oe  <= 1'b0;
              rsp_data <= rd_q ? shreg[15:0] : 16'h0000;
              rsp_err  <= rd_q && ta_err;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              shreg   <= {shreg[30:0], 1'b0};
              if (rd_q && (bit_cnt <= TA1_CNT + 6'd1)) begin
                mdio_o  <= 1'b1;
                mdio_oe <= 1'b0;
              end else begin
                mdio_o  <= shreg[30];
                mdio_oe <= 1'b1;
              end
            end
          end
        end

        S_GAP: begin
          if (fall_stb) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end

        S_ERR: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_ctrl.sv
// Self-checking bench for mdio_ctrl: a frame-level MDIO PHY model decodes the
// serial stream and answers reads; requests come from a table and $urandom.
module tb_mdio_ctrl;
  import mdio_pkg::*;

  localparam int CLK_DIV  = 2;
  localparam int PRE_LEN  = 32;
  localparam int LAT      = (PRE_LEN + 33) * 2 * CLK_DIV;
  localparam int CLK_DIV0 = 3;
  localparam int LAT0     = 33 * 2 * CLK_DIV0;
  localparam int MAXB     = 128;
  localparam int NTBL     = 8;

  typedef struct {
    logic        c45;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] data;
    logic        phy_present;
    logic [15:0] phy_data;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid = 1'b0;
  logic req_valid0 = 1'b0;
  logic req_c45 = 1'b0;
  logic [1:0] req_op = '0;
  logic [4:0] req_phyad = '0;
  logic [4:0] req_regad = '0;
  logic [15:0] req_data = '0;
  logic mdio_i = 1'b1;
  logic mdio_i0 = 1'b1;

  logic req_ready, rsp_valid, rsp_err, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_data;
  logic req_ready0, rsp_valid0, rsp_err0, mdc0, mdio_o0, mdio_oe0;
  logic [15:0] rsp_data0;

  int tests_run = 0;
  int tests_failed = 0;
  int rise_cnt = 0;
  int edge_viol = 0;
  int rsp_pulses = 0;
  int exp_pulses = 0;
  logic prev_mdc = 1'b0;
  logic prev_o = 1'b1;
  logic prev_oe = 1'b0;
  logic exp_o [MAXB];
  logic exp_oe [MAXB];
  logic drive_bits [MAXB];
  logic mon_o [$];
  logic mon_oe [$];
  vec_t tbl [NTBL];

  always #5 clk = ~clk;

  mdio_ctrl #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_c45(req_c45), .req_op(req_op), .req_phyad(req_phyad), .req_regad(req_regad),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_ctrl #(.CLK_DIV(CLK_DIV0), .PRE_LEN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_c45(req_c45), .req_op(req_op), .req_phyad(req_phyad), .req_regad(req_regad),
    .req_data(req_data), .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .rsp_err(rsp_err0),
    .mdc(mdc0), .mdio_o(mdio_o0), .mdio_oe(mdio_oe0), .mdio_i(mdio_i0)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One clock of PHY behaviour: record each bit at the MDC rise, present the
  // next response bit after the MDC fall, and police output timing.
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      if (mdc && !prev_mdc) begin
        mon_o.push_back(mdio_o);
        mon_oe.push_back(mdio_oe);
        rise_cnt++;
      end
      if (!mdc && prev_mdc && rise_cnt < MAXB) mdio_i = drive_bits[rise_cnt];
      if (mdc && (mdio_o != prev_o || mdio_oe != prev_oe)) edge_viol++;
      if (rsp_valid) rsp_pulses++;
    end
    prev_mdc = mdc;
    prev_o   = mdio_o;
    prev_oe  = mdio_oe;
  endtask

  function automatic logic ref_read(input vec_t v);
    return v.c45 ? v.op[1] : (v.op == 2'b10);
  endfunction

  function automatic logic ref_legal(input vec_t v);
    return v.c45 || (v.op == 2'b01) || (v.op == 2'b10);
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_data = (ref_legal(v) && ref_read(v)) ? (v.phy_present ? v.phy_data : 16'hFFFF) : 16'h0;
    r.exp_err  = !ref_legal(v) || (ref_read(v) && !v.phy_present);
    return r;
  endfunction

  // Expected line activity per MDC rise, and what the PHY puts on mdio_i.
  task automatic build_frame(input vec_t v, input int pre);
    logic [31:0] f;
    logic rd;
    rd = ref_read(v);
    f  = {(v.c45 ? 2'b00 : 2'b01), v.op, v.phyad, v.regad, 2'b10, v.data};
    for (int i = 0; i < MAXB; i++) begin
      exp_o[i] = 1'b1;
      exp_oe[i] = 1'b0;
      drive_bits[i] = 1'b1;
    end
    for (int i = 0; i < pre; i++) exp_oe[i] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_o[pre + i]  = f[31 - i];
      exp_oe[pre + i] = !(rd && i >= 14);
    end
    if (rd && v.phy_present) begin
      drive_bits[pre + 15] = 1'b0;
      for (int j = 0; j < 16; j++) drive_bits[pre + 16 + j] = v.phy_data[15 - j];
    end
  endtask

  task automatic check_frame(input string name, input int pre);
    int bad;
    int first_bad;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < mon_o.size() && i < MAXB; i++) begin
      if (mon_oe[i] !== exp_oe[i] || (exp_oe[i] && mon_o[i] !== exp_o[i])) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checkOutput({name, " frame bit errors"}, bad, 0);
    if (bad != 0) $display("[TB]   first wrong bit index %0d", first_bad);
    checkOutput({name, " mdc rises"}, mon_o.size(), pre + 33);
  endtask

  task automatic startReq(input vec_t v);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    checkOutput("req_ready before request", req_ready, 1);
    build_frame(v, PRE_LEN);
    mon_o.delete();
    mon_oe.delete();
    rise_cnt = 0;
    mdio_i = 1'b1;
    req_valid = 1'b1;
    req_c45 = v.c45;
    req_op = v.op;
    req_phyad = v.phyad;
    req_regad = v.regad;
    req_data = v.data;
    step();
    req_valid = 1'b0;
    req_c45 = 1'($urandom);
    req_op = 2'($urandom);
    req_phyad = 5'($urandom);
    req_regad = 5'($urandom);
    req_data = 16'($urandom);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int lat;
    logic legal;
    legal = ref_legal(v);
    startReq(v);
    exp_pulses++;
    lat = 1;
    while (!rsp_valid && lat < 4 * LAT) begin
      step();
      lat++;
    end
    checkOutput({name, " latency"}, lat, legal ? LAT : 1);
    checkOutput({name, " rsp_err"}, rsp_err, v.exp_err);
    if (legal) begin
      checkOutput({name, " rsp_data"}, rsp_data, v.exp_data);
      check_frame(name, PRE_LEN);
    end else begin
      checkOutput({name, " mdc rises"}, mon_o.size(), 0);
    end
    step();
    checkOutput({name, " rsp_valid single pulse"}, rsp_valid, 0);
    checkOutput({name, " req_ready after rsp"}, req_ready, 1);
  endtask

  initial begin
    vec_t v;
    int n;
    int lat;
    int aborted;
    logic p0;

    tbl[0] = '{c45:1'b0, op:OP_C22_WRITE, phyad:5'h01, regad:5'h00, data:16'h1140,
               phy_present:1'b0, phy_data:16'h0, exp_data:16'h0, exp_err:1'b0};
    tbl[1] = '{c45:1'b0, op:OP_C22_READ, phyad:5'h03, regad:5'h02, data:16'h0,
               phy_present:1'b1, phy_data:16'h0141, exp_data:16'h0141, exp_err:1'b0};
    tbl[2] = '{c45:1'b1, op:OP_C45_ADDR, phyad:5'h02, regad:5'h01, data:16'h0007,
               phy_present:1'b0, phy_data:16'h0, exp_data:16'h0, exp_err:1'b0};
    tbl[3] = '{c45:1'b1, op:OP_C45_READ, phyad:5'h02, regad:5'h01, data:16'h0,
               phy_present:1'b1, phy_data:16'hBEEF, exp_data:16'hBEEF, exp_err:1'b0};
    tbl[4] = '{c45:1'b0, op:OP_C22_READ, phyad:5'h07, regad:5'h01, data:16'h0,
               phy_present:1'b0, phy_data:16'h0, exp_data:16'hFFFF, exp_err:1'b1};
    tbl[5] = '{c45:1'b0, op:2'b11, phyad:5'h01, regad:5'h00, data:16'h0,
               phy_present:1'b0, phy_data:16'h0, exp_data:16'h0, exp_err:1'b1};
    tbl[6] = '{c45:1'b0, op:2'b00, phyad:5'h01, regad:5'h00, data:16'h0,
               phy_present:1'b0, phy_data:16'h0, exp_data:16'h0, exp_err:1'b1};
    tbl[7] = '{c45:1'b1, op:OP_C45_READ_INC, phyad:5'h1E, regad:5'h03, data:16'h0,
               phy_present:1'b1, phy_data:16'h1234, exp_data:16'h1234, exp_err:1'b0};

    #1 rst_n = 1'b0;
    repeat (3) step();
    checkOutput("reset req_ready", req_ready, 0);
    checkOutput("reset mdc", mdc, 0);
    checkOutput("reset mdio_oe", mdio_oe, 0);
    checkOutput("reset mdio_o", mdio_o, 1);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    #1 rst_n = 1'b1;
    step();
    checkOutput("req_ready after release", req_ready, 1);

    for (int i = 0; i < NTBL; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      v.c45 = 1'($urandom);
      v.op = 2'($urandom);
      v.phyad = 5'($urandom);
      v.regad = 5'($urandom);
      v.data = 16'($urandom);
      v.phy_present = ($urandom_range(0, 3) != 0);
      v.phy_data = 16'($urandom);
      v.exp_data = '0;
      v.exp_err = 1'b0;
      applyStimulus(model(v), $sformatf("rand%0d", i));
    end

    // Abort a read in its DATA field, after a BEEF read left rsp_data nonzero.
    applyStimulus(tbl[3], "pre-abort read");
    startReq(tbl[1]);
    n = 0;
    while (rise_cnt < PRE_LEN + 22 && n < 4 * LAT) begin
      step();
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort mdc", mdc, 0);
    checkOutput("abort mdio_oe", mdio_oe, 0);
    checkOutput("abort mdio_o", mdio_o, 1);
    checkOutput("abort req_ready", req_ready, 0);
    checkOutput("abort rsp_valid", rsp_valid, 0);
    checkOutput("abort rsp_data", rsp_data, 0);
    checkOutput("abort rsp_err", rsp_err, 0);
    aborted = 0;
    repeat (10) begin
      step();
      if (rsp_valid || mdc) aborted++;
    end
    checkOutput("abort quiet during reset", aborted, 0);
    #1 rst_n = 1'b1;
    step();
    checkOutput("req_ready first clock after abort", req_ready, 1);
    applyStimulus(tbl[1], "read after abort");

    // Preamble-suppressed write on the second instance.
    v = '{c45:1'b0, op:OP_C22_WRITE, phyad:5'h1F, regad:5'h0A, data:16'hA55A,
          phy_present:1'b0, phy_data:16'h0, exp_data:16'h0, exp_err:1'b0};
    n = 0;
    while (!req_ready0 && n < 200) begin
      step();
      n++;
    end
    build_frame(v, 0);
    mon_o.delete();
    mon_oe.delete();
    p0 = mdc0;
    req_valid0 = 1'b1;
    req_c45 = v.c45;
    req_op = v.op;
    req_phyad = v.phyad;
    req_regad = v.regad;
    req_data = v.data;
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        req_valid0 = 1'b0;
        req_data = 16'($urandom);
        req_op = 2'($urandom);
      end
      if (mdc0 && !p0) begin
        mon_o.push_back(mdio_o0);
        mon_oe.push_back(mdio_oe0);
      end
      p0 = mdc0;
    end while (!rsp_valid0 && lat < 4 * LAT0);
    checkOutput("nopre latency", lat, LAT0);
    checkOutput("nopre first rise carries ST", (mon_o.size() > 0) ? mon_o[0] : 1'bx, 0);
    check_frame("nopre", 0);
    checkOutput("nopre rsp_err", rsp_err0, 0);
    checkOutput("nopre rsp_data", rsp_data0, 0);

    checkOutput("mdio changes while mdc high", edge_viol, 0);
    checkOutput("rsp_valid pulse count", rsp_pulses, exp_pulses);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
